// File: rtl/sr_reg_watch.sv
`default_nettype none
// ============================================================================
// Module   : sr_reg_watch
// Brief    : Register-file debug-port monitor. Watches one register for an
//            expected result, times out otherwise, and logs every change of
//            the watched value with its sample index into a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sr_reg_watch #(
    parameter logic [4:0]  REG_ADDR   = 5'd10,
    parameter logic [31:0] EXP_A      = 32'h00213d05,
    parameter logic [31:0] EXP_B      = 32'h1c8cfc00,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [15:0] cycle_count,
    output logic        chg_valid,
    input  logic        chg_ready,
    output logic [31:0] chg_data,
    output logic [15:0] chg_cycle,
    output logic        chg_overflow
);

    localparam int unsigned     AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned     CW       = AW + 1;
    localparam logic [15:0]     C_LAST_K = 16'(TIMEOUT - 1);
    localparam logic [CW-1:0]   C_DEPTH  = CW'(FIFO_DEPTH);
    localparam logic [15:0]     C_K_MAX  = 16'hFFFF;

    localparam logic [1:0] ST_ARM  = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    generate
        if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("sr_reg_watch: TIMEOUT must lie in 2..65535");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sr_reg_watch: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [1:0]     state_q, state_d;
    logic [15:0]    cycle_count_q, cycle_count_d;
    logic [31:0]    prev_q, prev_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [47:0]    mem_q [FIFO_DEPTH];

    logic           w_sample_en;
    logic           w_is_arm;
    logic           w_match;
    logic           w_timeout;
    logic           w_push_req;
    logic           w_pop;
    logic           w_full;
    logic           w_push_ok;
    logic [47:0]    w_head;

    assign regAddr   = REG_ADDR;
    assign w_match   = (regData == EXP_A) || (regData == EXP_B);
    assign w_timeout = (cycle_count_q == C_LAST_K);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM, ST_RUN: begin
                if (w_match) begin
                    state_d = ST_PASS;
                end else if (w_timeout) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_sample_en = 1'b0;
        w_is_arm    = 1'b0;
        done        = 1'b0;
        pass        = 1'b0;
        fail        = 1'b0;
        case (state_q)
            ST_ARM: begin
                w_sample_en = 1'b1;
                w_is_arm    = 1'b1;
            end
            ST_RUN: begin
                w_sample_en = 1'b1;
            end
            ST_PASS: begin
                done = 1'b1;
                pass = 1'b1;
            end
            default: begin
                done = 1'b1;
                fail = 1'b1;
            end
        endcase
    end

    // ---------------- Sampling and change detection ----------------
    always_comb begin
        cycle_count_d = cycle_count_q;
        prev_d        = prev_q;
        w_push_req    = 1'b0;
        if (w_sample_en) begin
            if (cycle_count_q != C_K_MAX) begin
                cycle_count_d = cycle_count_q + 16'd1;
            end
            // prev tracks the bus even when the push is dropped on a full log
            prev_d     = regData;
            w_push_req = w_is_arm || (regData != prev_q);
        end
    end

    // ---------------- Change-log FIFO control ----------------
    always_comb begin
        w_full     = (count_q == C_DEPTH);
        w_pop      = (count_q != '0) && chg_ready;
        w_push_ok  = w_push_req && (!w_full || w_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (w_push_ok && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (w_pop && !w_push_ok) begin
            count_d = count_q - CW'(1);
        end
        if (w_push_req && !w_push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= '0;
            prev_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            cycle_count_q <= cycle_count_d;
            prev_q        <= prev_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            mem_q[wr_ptr_q] <= {cycle_count_q, regData};
        end
    end

    assign w_head       = mem_q[rd_ptr_q];
    assign chg_valid    = (count_q != '0);
    assign chg_data     = chg_valid ? w_head[31:0]  : 32'd0;
    assign chg_cycle    = chg_valid ? w_head[47:32] : 16'd0;
    assign chg_overflow = overflow_q;
    assign cycle_count  = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_reg_watch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_reg_watch
// Brief    : Directed bench for sr_reg_watch with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_reg_watch;

    localparam int unsigned TB_TIMEOUT = 16;
    localparam int unsigned TB_DEPTH   = 4;
    localparam logic [31:0] TB_EXP_A   = 32'h00213d05;
    localparam logic [31:0] TB_EXP_B   = 32'h1c8cfc00;

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] dat;
    } ent_t;

    logic        clk;
    logic        rst;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        done;
    logic        pass;
    logic        fail;
    logic [15:0] cycle_count;
    logic        chg_valid;
    logic        chg_ready;
    logic [31:0] chg_data;
    logic [15:0] chg_cycle;
    logic        chg_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    sr_reg_watch #(
        .REG_ADDR   (5'd10),
        .EXP_A      (TB_EXP_A),
        .EXP_B      (TB_EXP_B),
        .TIMEOUT    (TB_TIMEOUT),
        .FIFO_DEPTH (TB_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .regAddr      (regAddr),
        .regData      (regData),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .cycle_count  (cycle_count),
        .chg_valid    (chg_valid),
        .chg_ready    (chg_ready),
        .chg_data     (chg_data),
        .chg_cycle    (chg_cycle),
        .chg_overflow (chg_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: the log is a plain queue, the verdict a small integer.
    ent_t        mq[$];
    int unsigned mk;
    logic [31:0] mprev;
    bit          marmed;
    int          mverdict;      // 0 running, 1 pass, 2 fail
    bit          movf;
    bit          model_ok = 1'b0;
    bit          m_pop;
    bit          m_push;
    bit          m_full;
    ent_t        m_e;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mk       = 0;
            mprev    = '0;
            marmed   = 1'b0;
            mverdict = 0;
            movf     = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_pop  = (mq.size() > 0) && chg_ready;
            m_full = (mq.size() == TB_DEPTH);
            m_push = 1'b0;
            if (mverdict == 0) begin
                if (!marmed || regData != mprev) begin
                    m_push = 1'b1;
                    m_e    = {mk[15:0], regData};
                end
                mprev  = regData;
                marmed = 1'b1;
                if (regData == TB_EXP_A || regData == TB_EXP_B) mverdict = 1;
                else if (mk == TB_TIMEOUT - 1)                  mverdict = 2;
                if (mk < 65535) mk++;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (!m_full || m_pop) mq.push_back(m_e);
                else                  movf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("regAddr",     regAddr,      5'd10);
            chk("done",        done,         mverdict != 0);
            chk("pass",        pass,         mverdict == 1);
            chk("fail",        fail,         mverdict == 2);
            chk("cycle_count", cycle_count,  mk[15:0]);
            chk("chg_valid",   chg_valid,    mq.size() > 0);
            chk("chg_data",    chg_data,     (mq.size() > 0) ? mq[0].dat : 32'd0);
            chk("chg_cycle",   chg_cycle,    (mq.size() > 0) ? mq[0].cyc : 16'd0);
            chk("chg_overflow", chg_overflow, movf);
        end
    end

    // Entries the DUT hands out, captured at the moment they are accepted.
    ent_t cap[$];

    task automatic cyc(input logic [31:0] d, input logic rdy);
        regData   = d;
        chg_ready = rdy;
        if (chg_valid && rdy) cap.push_back({chg_cycle, chg_data});
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc(32'd0, 1'b0);
        rst = 1'b0;
        cap.delete();
    endtask

    task automatic chk_cap(input int i, input logic [15:0] c, input logic [31:0] d);
        if (i < cap.size()) begin
            chk($sformatf("log%0d_cycle", i), cap[i].cyc, c);
            chk($sformatf("log%0d_data", i),  cap[i].dat, d);
        end else begin
            chk($sformatf("log%0d_present", i), cap.size(), i + 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        rst       = 1'b1;
        regData   = '0;
        chg_ready = 1'b0;

        // 1: zeros then Fibonacci result at sample 5
        do_reset(2);
        chk("t1_reset_valid", chg_valid, 1'b0);
        chk("t1_reset_cnt",   cycle_count, 16'd0);
        for (int s = 0; s < 5; s++) cyc(32'd0, 1'b0);
        cyc(32'h00213d05, 1'b0);
        chk("t1_pass", pass, 1'b1);
        chk("t1_done", done, 1'b1);
        chk("t1_fail", fail, 1'b0);
        chk("t1_cnt",  cycle_count, 16'd6);
        for (int i = 0; i < 3; i++) cyc(32'h1234, 1'b1);
        chk("t1_drained", chg_valid, 1'b0);
        chk("t1_log_n", cap.size(), 2);
        chk_cap(0, 16'd0, 32'd0);
        chk_cap(1, 16'd5, 32'h00213d05);

        // 2: factorial progression reaching 12! at sample 12
        do_reset(1);
        cyc(32'd0, 1'b1);
        f = 32'd1;
        for (int i = 1; i <= 12; i++) begin
            f = f * 32'(i);
            cyc(f, 1'b1);
        end
        chk("t2_pass", pass, 1'b1);
        chk("t2_cnt",  cycle_count, 16'd13);
        for (int i = 0; i < 3; i++) cyc(32'd7, 1'b1);
        chk("t2_log_n", cap.size(), 13);
        f = 32'd1;
        chk_cap(0, 16'd0, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            f = f * 32'(i);
            chk_cap(i, 16'(i), f);
        end
        chk("t2_lit_12fact", f, 32'h1c8cfc00);

        // 3: constant value times out
        do_reset(1);
        for (int s = 0; s < 16; s++) cyc(32'h5, 1'b0);
        chk("t3_fail", fail, 1'b1);
        chk("t3_done", done, 1'b1);
        chk("t3_pass", pass, 1'b0);
        chk("t3_cnt",  cycle_count, 16'd16);
        chk("t3_head_data",  chg_data, 32'h5);
        chk("t3_head_cycle", chg_cycle, 16'd0);
        for (int i = 0; i < 10; i++) cyc(32'h77 + 32'(i), 1'b0);
        chk("t3_cnt_frozen", cycle_count, 16'd16);
        cyc(32'h0, 1'b1);
        chk("t3_single_entry", chg_valid, 1'b0);

        // 4: overflow with consumer stalled, then drain
        do_reset(1);
        for (int s = 0; s < 4; s++) cyc(32'(s + 1), 1'b0);
        chk("t4_no_ovf_yet", chg_overflow, 1'b0);
        cyc(32'd5, 1'b0);
        chk("t4_ovf", chg_overflow, 1'b1);
        for (int i = 0; i < 4; i++) cyc(32'd5, 1'b1);
        chk("t4_empty", chg_valid, 1'b0);
        chk("t4_log_n", cap.size(), 4);
        for (int i = 0; i < 4; i++) chk_cap(i, 16'(i), 32'(i + 1));

        // 5: full FIFO, pop and push on the same cycle
        do_reset(1);
        for (int s = 0; s < 4; s++) cyc(32'(s + 1), 1'b0);
        cyc(32'd10, 1'b1);
        chk("t5_no_ovf", chg_overflow, 1'b0);
        chk("t5_head_cycle", chg_cycle, 16'd1);
        for (int i = 0; i < 4; i++) cyc(32'd10, 1'b1);
        chk("t5_empty", chg_valid, 1'b0);
        chk("t5_log_n", cap.size(), 5);
        chk_cap(1, 16'd1, 32'd2);
        chk_cap(2, 16'd2, 32'd3);
        chk_cap(3, 16'd3, 32'd4);
        chk_cap(4, 16'd4, 32'd10);

        // 6: reset in the middle of a run with entries pending
        do_reset(1);
        cyc(32'd1, 1'b0); cyc(32'd1, 1'b0);
        cyc(32'd2, 1'b0); cyc(32'd2, 1'b0);
        cyc(32'd3, 1'b0); cyc(32'd3, 1'b0); cyc(32'd3, 1'b0);
        chk("t6_pending", chg_valid, 1'b1);
        rst = 1'b1;
        cyc(32'd4, 1'b0);
        rst = 1'b0;
        chk("t6_valid", chg_valid, 1'b0);
        chk("t6_cnt",   cycle_count, 16'd0);
        chk("t6_done",  done, 1'b0);
        cyc(32'd9, 1'b0);
        chk("t6_arm_data",  chg_data, 32'd9);
        chk("t6_arm_cycle", chg_cycle, 16'd0);
        chk("t6_cnt1",      cycle_count, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
